// File: rtl/guess_game_pkg.sv
// rtl/guess_game_pkg.sv - shared types, hint codes and width-mask helper for the guessing game
package guess_game_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_JUDGE,
    ST_PASS,
    ST_WIN,
    ST_FAIL
  } state_t;

  localparam logic [1:0] HINT_NONE = 2'b00;
  localparam logic [1:0] HINT_LOW  = 2'b01;
  localparam logic [1:0] HINT_HIGH = 2'b10;
  localparam logic [1:0] HINT_OK   = 2'b11;

  // All-ones mask of the low w bits; callers truncate to their own width.
  function automatic logic [31:0] mask_of(input int unsigned w);
    if (w >= 32) begin
      return '1;
    end
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/guess_game_ctrl_level_timer.sv
// rtl/guess_game_ctrl_level_timer.sv - per-level countdown seconds counter
module level_timer #(
  parameter int TIME_S = 30,
  parameter int TW     = $clog2(TIME_S + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          tick,
  output logic [TW-1:0] count,
  output logic          expire
);

  // Load has priority; a tick at zero is absorbed so the counter never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= TW'(TIME_S);
    end else if (tick && (count != '0)) begin
      count <= count - TW'(1);
    end
  end

  // Flags the tick that takes the count from 1 to 0.
  assign expire = tick && !load && (count == TW'(1));

endmodule

// File: rtl/guess_game_ctrl.sv
// rtl/guess_game_ctrl.sv - number-guessing game sequencer: levels, countdown, tries, outcome
module guess_game_ctrl
  import guess_game_pkg::*;
#(
  parameter int LEVELS    = 3,
  parameter int BASE_W    = 5,
  parameter int MAX_TRIES = 3,
  parameter int TIME_S    = 30,
  localparam int MAXW     = BASE_W + LEVELS - 1,
  localparam int LW       = (LEVELS > 1) ? $clog2(LEVELS) : 1,
  localparam int TW       = $clog2(TIME_S + 1),
  localparam int NW       = $clog2(MAX_TRIES + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            start,
  input  logic            guess_vld,
  input  logic [MAXW-1:0] guess,
  input  logic            tick_1s,
  input  logic [MAXW-1:0] rand_num,
  output logic            rand_st,
  output logic            greet,
  output logic [LW-1:0]   level,
  output logic [TW-1:0]   time_left,
  output logic [NW-1:0]   tries_left,
  output logic [1:0]      hint,
  output logic            beep,
  output logic            win,
  output logic            lose
);

  state_t          state_q;
  state_t          state_nx;
  logic [LW-1:0]   level_q;
  logic [NW-1:0]   tries_q;
  logic [1:0]      hint_q;
  logic [MAXW-1:0] target_q;
  logic [MAXW-1:0] guess_q;
  logic            beep_q;

  logic [MAXW-1:0] base_mask;
  logic [MAXW-1:0] cur_mask;
  logic [MAXW-1:0] nxt_mask;
  logic            timer_load;
  logic            timer_tick;
  logic            timer_expire;
  logic            guess_hit;
  logic            last_level;

  assign base_mask = MAXW'(mask_of(BASE_W));
  assign cur_mask  = MAXW'(mask_of(BASE_W + int'(level_q)));
  assign nxt_mask  = MAXW'(mask_of(BASE_W + int'(level_q) + 1));

  assign guess_hit  = (guess_q == target_q);
  assign last_level = (level_q == LW'(LEVELS - 1));

  // A tick only counts in PLAY when nothing of higher priority happens that cycle.
  assign timer_load = en && ((state_q == ST_LOAD) || (state_q == ST_PASS));
  assign timer_tick = en && (state_q == ST_PLAY) && tick_1s && !start && !guess_vld;

  level_timer #(
    .TIME_S (TIME_S),
    .TW     (TW)
  ) u_level_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .tick   (timer_tick),
    .count  (time_left),
    .expire (timer_expire)
  );

  // Next-state selection; losing power overrides everything.
  always_comb begin
    state_nx = state_q;
    if (!en) begin
      state_nx = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF:  state_nx = ST_IDLE;
        ST_IDLE: if (start) state_nx = ST_LOAD;
        ST_LOAD: state_nx = ST_PLAY;
        ST_PLAY: begin
          if (start) begin
            state_nx = ST_LOAD;
          end else if (guess_vld) begin
            state_nx = ST_JUDGE;
          end else if (timer_expire) begin
            state_nx = ST_FAIL;
          end
        end
        ST_JUDGE: begin
          if (guess_hit) begin
            state_nx = last_level ? ST_WIN : ST_PASS;
          end else if (tries_q <= NW'(1)) begin
            state_nx = ST_FAIL;
          end else begin
            state_nx = ST_PLAY;
          end
        end
        ST_PASS: state_nx = ST_PLAY;
        ST_WIN:  if (start) state_nx = ST_LOAD;
        ST_FAIL: if (start) state_nx = ST_LOAD;
        default: state_nx = ST_OFF;
      endcase
    end
  end

  // State register; beep marks the first cycle of PASS, WIN or FAIL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      beep_q  <= 1'b0;
    end else begin
      state_q <= state_nx;
      beep_q  <= (state_nx != state_q) &&
                 ((state_nx == ST_PASS) || (state_nx == ST_WIN) || (state_nx == ST_FAIL));
    end
  end

  // Level, target, captured guess, tries and hint; frozen while powered off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q  <= '0;
      tries_q  <= '0;
      hint_q   <= HINT_NONE;
      target_q <= '0;
      guess_q  <= '0;
    end else if (en) begin
      case (state_q)
        ST_LOAD: begin
          level_q  <= '0;
          target_q <= rand_num & base_mask;
          tries_q  <= NW'(MAX_TRIES);
          hint_q   <= HINT_NONE;
        end
        ST_PLAY: begin
          if (!start && guess_vld) begin
            guess_q <= guess & cur_mask;
          end
        end
        ST_JUDGE: begin
          if (guess_hit) begin
            hint_q <= HINT_OK;
          end else begin
            hint_q <= (guess_q < target_q) ? HINT_LOW : HINT_HIGH;
            if (tries_q != '0) begin
              tries_q <= tries_q - NW'(1);
            end
          end
        end
        ST_PASS: begin
          level_q  <= level_q + LW'(1);
          target_q <= rand_num & nxt_mask;
          tries_q  <= NW'(MAX_TRIES);
        end
        default: begin
        end
      endcase
    end
  end

  assign rand_st    = (state_q != ST_OFF);
  assign greet      = (state_q == ST_IDLE);
  assign win        = (state_q == ST_WIN);
  assign lose       = (state_q == ST_FAIL);
  assign beep       = beep_q;
  assign level      = level_q;
  assign tries_left = tries_q;
  assign hint       = hint_q;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// tb/tb_guess_game_ctrl.sv - directed self-checking bench for guess_game_ctrl
module tb_guess_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_a = 1'b0;
  logic       en_b = 1'b0;
  logic       start = 1'b0;
  logic       guess_vld = 1'b0;
  logic       tick_1s = 1'b0;
  logic [6:0] guess = '0;
  logic [6:0] rand_num = '0;

  logic       a_rand_st, a_greet, a_beep, a_win, a_lose;
  logic [1:0] a_level, a_tries, a_hint;
  logic [4:0] a_time;

  logic       b_rand_st, b_greet, b_beep, b_win, b_lose;
  logic [1:0] b_level, b_tries, b_hint, b_time;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  guess_game_ctrl dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en_a),
    .start      (start),
    .guess_vld  (guess_vld),
    .guess      (guess),
    .tick_1s    (tick_1s),
    .rand_num   (rand_num),
    .rand_st    (a_rand_st),
    .greet      (a_greet),
    .level      (a_level),
    .time_left  (a_time),
    .tries_left (a_tries),
    .hint       (a_hint),
    .beep       (a_beep),
    .win        (a_win),
    .lose       (a_lose)
  );

  guess_game_ctrl #(
    .LEVELS    (4),
    .BASE_W    (3),
    .MAX_TRIES (3),
    .TIME_S    (2)
  ) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en_b),
    .start      (start),
    .guess_vld  (guess_vld),
    .guess      (guess[5:0]),
    .tick_1s    (tick_1s),
    .rand_num   (rand_num[5:0]),
    .rand_st    (b_rand_st),
    .greet      (b_greet),
    .level      (b_level),
    .time_left  (b_time),
    .tries_left (b_tries),
    .hint       (b_hint),
    .beep       (b_beep),
    .win        (b_win),
    .lose       (b_lose)
  );

  task automatic check(input string tag, input int act, input int exp);
    chk_cnt++;
    if (act == exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
  endtask

  task automatic submit(input logic [6:0] g);
    guess     = g;
    guess_vld = 1'b1;
    cyc();
    guess_vld = 1'b0;
    cyc();
  endtask

  task automatic tick();
    tick_1s = 1'b1;
    cyc();
    tick_1s = 1'b0;
  endtask

  logic [6:0] g;
  logic [6:0] m;
  logic [6:0] tgt_b [1:3];

  initial begin
    tgt_b[1] = 7'h0D;
    tgt_b[2] = 7'h0D;
    tgt_b[3] = 7'h2D;

    #2;
    check("rst_hint",    int'(a_hint), 0);
    check("rst_tries",   int'(a_tries), 0);
    check("rst_time",    int'(a_time), 0);
    check("rst_level",   int'(a_level), 0);
    check("rst_flags",   int'({a_rand_st, a_greet, a_beep, a_win, a_lose}), 0);
    check("rst_b_flags", int'({b_rand_st, b_greet, b_beep, b_win, b_lose}), 0);

    cyc();
    rst_n    = 1'b1;
    en_a     = 1'b1;
    rand_num = 7'h25;
    cyc();
    check("idle_greet", int'(a_greet), 1);
    check("idle_rst",   int'(a_rand_st), 1);

    start_game();
    check("play_tries", int'(a_tries), 3);
    check("play_time",  int'(a_time), 30);
    check("play_greet", int'(a_greet), 0);

    submit(7'h05);
    check("l0_hint",  int'(a_hint), 3);
    check("l0_beep",  int'(a_beep), 1);
    check("l0_level", int'(a_level), 0);
    cyc();
    check("l1_level", int'(a_level), 1);
    check("l1_beep",  int'(a_beep), 0);

    submit(7'h65);
    check("l1_hint", int'(a_hint), 3);
    cyc();
    check("l2_level", int'(a_level), 2);

    submit(7'h25);
    check("win_flag", int'(a_win), 1);
    check("win_beep", int'(a_beep), 1);
    cyc();
    check("win_hold", int'(a_win), 1);
    check("win_beep_off", int'(a_beep), 0);

    start_game();
    check("restart_level", int'(a_level), 0);
    check("restart_hint",  int'(a_hint), 0);
    submit(7'h01);
    check("w1_hint",  int'(a_hint), 1);
    check("w1_tries", int'(a_tries), 2);
    submit(7'h1F);
    check("w2_hint",  int'(a_hint), 2);
    check("w2_tries", int'(a_tries), 1);
    check("w2_lose",  int'(a_lose), 0);
    submit(7'h00);
    check("w3_hint",  int'(a_hint), 1);
    check("w3_tries", int'(a_tries), 0);
    check("w3_lose",  int'(a_lose), 1);
    check("w3_beep",  int'(a_beep), 1);
    cyc();
    check("fail_beep_off", int'(a_beep), 0);
    check("fail_hold",     int'(a_lose), 1);

    start_game();
    tick();
    check("tick_time", int'(a_time), 29);
    en_a = 1'b0;
    cyc();
    check("off_rand_st", int'(a_rand_st), 0);
    check("off_time",    int'(a_time), 29);
    en_a = 1'b1;
    cyc();
    check("reon_greet", int'(a_greet), 1);
    check("reon_tries", int'(a_tries), 3);

    start_game();
    guess     = 7'h05;
    guess_vld = 1'b1;
    cyc();
    guess_vld = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("arst_tries", int'(a_tries), 0);
    check("arst_time",  int'(a_time), 0);
    check("arst_flags", int'({a_rand_st, a_greet, a_beep, a_win, a_lose}), 0);
    cyc();
    rst_n = 1'b1;
    en_a  = 1'b0;

    en_b     = 1'b1;
    rand_num = 7'h2D;
    cyc();
    start_game();
    check("b_time0", int'(b_time), 2);
    tick();
    check("b_time1", int'(b_time), 1);
    g         = 7'($urandom);
    guess     = {g[6:3], 3'h5};
    guess_vld = 1'b1;
    tick_1s   = 1'b1;
    cyc();
    guess_vld = 1'b0;
    tick_1s   = 1'b0;
    cyc();
    check("b_race_lose", int'(b_lose), 0);
    check("b_race_hint", int'(b_hint), 3);
    check("b_race_beep", int'(b_beep), 1);
    cyc();
    check("b_l1_level", int'(b_level), 1);
    check("b_l1_time",  int'(b_time), 2);

    for (int k = 1; k <= 3; k++) begin
      m = 7'((1 << (3 + k)) - 1);
      g = 7'($urandom);
      submit((g & ~m) | tgt_b[k]);
      check($sformatf("b_l%0d_hint", k), int'(b_hint), 3);
      if (k < 3) begin
        cyc();
        check($sformatf("b_l%0d_next", k), int'(b_level), k + 1);
      end
    end
    check("b_win",   int'(b_win), 1);
    check("b_level", int'(b_level), 3);

    start_game();
    tick();
    check("b_to_time1", int'(b_time), 1);
    tick();
    check("b_to_time0", int'(b_time), 0);
    check("b_to_lose",  int'(b_lose), 1);
    check("b_to_beep",  int'(b_beep), 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
